l0_row_feeder: RTL and testbench
================================

# l0_row_feeder

Input staging buffer that sits directly west of the systolic MAC array. It accepts one word per array row per write, buffers each row in its own FIFO, and drains the rows with a one-cycle-per-row diagonal skew. Each row's `in_w` data and its 2-bit `inst_w` instruction (bit 1 execute, bit 0 kernel load) arrive at the leftmost MAC tile of that row aligned, so the wavefront propagates correctly through the tiles.

## Interface
- `row`, 8, number of array rows (FIFO lanes).
- `bw`, 4, data width per row word; matches the MAC tile `bw`.
- `depth`, 64, entries per row FIFO; power of two, ≥ 2.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `wr`  in  1  push `in` into all row FIFOs; ignored while `o_full`.
- `in`  in  row*bw  row i word at bits [i*bw +: bw].
- `rd`  in  1  read launch for row 0; propagated to row i i cycles later.
- `inst_in`  in  2  instruction sampled with `rd`; skewed with it.
- `out`  out  row*bw  registered row data to `in_w` of tile (i,0).
- `inst_out`  out  2*row  registered per-row instruction to `inst_w` of tile (i,0).
- `o_valid`  out  row  row i produced a word this cycle.
- `o_full`  out  1  at least one row FIFO is full.
- `o_empty`  out  1  all row FIFOs are empty.

## Operation
- Each row has a FIFO of `depth` entries with read/write pointers of log2(depth)+1 bits; the MSB is the wrap bit. The FIFO is full when the pointers differ only in the MSB and empty when they are equal.
- Push: when `wr && !o_full`, all rows write `in` slice i and advance their write pointers together. When `wr && o_full`, nothing is written and no pointer moves.
- Skew chain: `rd_q[0] = rd`. Each later stage `rd_q[i]` is `rd_q[i-1]` delayed by one register, so row i sees a read request i cycles after `rd`. The `inst_in` value rides in the same chain alongside the read request.
- Pop: row i pops when its `rd_q[i]` is set and its FIFO is not empty. On the next edge:
  - `out[i]` takes the head entry and `o_valid[i]` = 1.
  - `inst_out[i]` takes the skewed instruction.
- A request on an empty row is dropped:
  - `o_valid[i]` = 0.
  - `out[i]` holds its previous value.
  - `inst_out[i]` = 2'b00, so the tile neither loads nor executes.
- With no request on a row, `o_valid[i]` = 0 and `inst_out[i]` = 2'b00.
- Push and pop on the same row in the same cycle both take effect, and the occupancy is unchanged. A push into a full FIFO is refused even if a pop occurs in that cycle; `o_full` is a registered-pointer comparison only.
- Pointers wrap modulo 2*depth, so the array index is the low log2(depth) bits.
- Reset clears all pointers, the skew chain, `out`, `inst_out` and `o_valid` to 0. Afterwards `o_empty` = 1 and `o_full` = 0. Reset mid-drain discards all buffered and in-flight data, and no `o_valid` pulse follows reset.

## Timing
- Write-to-read: a word pushed at edge t can be popped by a request at edge t+1 or later.
- Read latency for row i: `rd` high at edge t gives `o_valid[i]` and `out[i]` after edge t+1+i.
- A continuous `rd` burst of N cycles yields N consecutive valid words per row, offset diagonally.
- `o_full` and `o_empty` are combinational from the registered pointers and update the cycle after a push or pop.
- The skew chain keeps running after `rd` falls. Row row-1 finishes row-1 cycles after row 0.

## Structure
- Sub-module `l0_row_fifo`, parameters `bw` and `depth`, instantiated `row` times. Ports:
  - clk, reset, wr, rd, din, dout (registered), full, empty, valid.
- Top level contains only the rd/inst skew chain, instruction gating and full/empty reduction.
- Shared constants file: instruction encodings `INST_IDLE` = 2'b00, `INST_LOAD` = 2'b01, `INST_EXEC` = 2'b10. Pointer width is a localparam computed from `depth` via `$clog2`.

## Test plan
- Reset then idle: hold `rd` = 0 for 10 cycles. Require `out` = 0, `inst_out` = 0, `o_valid` = 0, `o_empty` = 1, `o_full` = 0.
- Skew: push one vector with row i = i+1. Pulse `rd` with `inst_in` = 2'b01 at edge t. Require row i to show value i+1 with `inst_out` = 01 at edge t+1+i only.
- Full and wrap (depth 64):
  - Push 64 vectors with values 0..63. Then `o_full` = 1, and a 65th push with value 0xF is ignored.
  - Drain, push 3 more, drain again. The order must be preserved across the pointer wrap.
- Underflow: with 2 entries, hold `rd` for 4 cycles. Each row gives exactly 2 valid words. Then `inst_out` = 00, `out` holds its last value, and pointers do not move.
- Simultaneous: at 63 entries, push and pop every cycle for 20 cycles. `o_full` never rises and data order is intact.
- Reset mid-drain: assert `reset` while row 3 is outputting. The next cycle all outputs = 0 and `o_empty` = 1. Later pops return only data pushed after reset.

Source files
------------

// File: rtl/l0_row_feeder_pkg.sv
// l0_row_feeder_pkg
//   Shared constants for the west-edge row feeder of the systolic MAC array:
//   the 2-bit tile instruction encodings and the FIFO pointer-width helper.
package l0_row_feeder_pkg;

  typedef logic [1:0] inst_t;

  // Tile instruction encodings (bit 1 execute, bit 0 kernel load).
  localparam inst_t INST_IDLE = 2'b00;
  localparam inst_t INST_LOAD = 2'b01;
  localparam inst_t INST_EXEC = 2'b10;

  // Pointer width for a FIFO of d entries: index bits plus one wrap bit.
  function automatic int ptr_width(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/l0_row_feeder_if.sv
// l0_row_feeder_if
//   Bundles the feeder's write side, read launch and per-row outputs.
//   master : producer/consumer side (drives wr, in, rd, inst_in)
//   slave  : the feeder itself (drives out, inst_out, o_valid, o_full, o_empty)
interface l0_row_feeder_if
  import l0_row_feeder_pkg::*;
#(
  parameter int row = 8,
  parameter int bw  = 4
);

  logic                wr;
  logic [row*bw-1:0]   in;
  logic                rd;
  inst_t               inst_in;
  logic [row*bw-1:0]   out;
  logic [2*row-1:0]    inst_out;
  logic [row-1:0]      o_valid;
  logic                o_full;
  logic                o_empty;

  modport master (
    output wr, in, rd, inst_in,
    input  out, inst_out, o_valid, o_full, o_empty
  );

  modport slave (
    input  wr, in, rd, inst_in,
    output out, inst_out, o_valid, o_full, o_empty
  );

endinterface

// File: rtl/l0_row_fifo.sv
// l0_row_fifo
//   Single-row FIFO lane of the feeder.
//   clk, reset : clock, synchronous active-high reset
//   wr, din    : push request and data (refused while full)
//   rd         : pop request (dropped while empty)
//   dout       : registered head word, holds its value when no pop occurs
//   valid      : dout was updated by a pop on the last edge
//   full/empty : combinational from the registered pointers
module l0_row_fifo
  import l0_row_feeder_pkg::*;
#(
  parameter int bw    = 4,
  parameter int depth = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          rd,
  input  logic [bw-1:0] din,
  output logic [bw-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          valid
);

  localparam int PTR_W  = ptr_width(depth);
  localparam int ADDR_W = PTR_W - 1;

  logic [bw-1:0]    mem [depth];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             push;
  logic             pop;

  // Same index with differing wrap bits means the writer is a full lap ahead.
  assign full  = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                 (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign empty = (wptr == rptr);
  assign push  = wr && !full;
  assign pop   = rd && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[ADDR_W-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
        dout <= mem[rptr[ADDR_W-1:0]];
      end
      valid <= pop;
    end
  end

endmodule

// File: rtl/l0_row_feeder.sv
// l0_row_feeder
//   Input staging buffer west of the systolic MAC array. One word per row is
//   pushed into per-row FIFOs; rows are drained with a one-cycle-per-row
//   diagonal skew so in_w data and inst_w arrive at each row's leftmost tile
//   aligned with the wavefront.
//   clk, reset : clock, synchronous active-high reset
//   bus        : l0_row_feeder_if slave modport
//                wr/in      push one word per row (ignored while o_full)
//                rd/inst_in read launch for row 0 with its instruction
//                out        registered row data, row i at [i*bw +: bw]
//                inst_out   registered row instruction, row i at [2*i +: 2]
//                o_valid    row i produced a word this cycle
//                o_full     at least one row FIFO is full
//                o_empty    all row FIFOs are empty
module l0_row_feeder
  import l0_row_feeder_pkg::*;
#(
  parameter int row   = 8,
  parameter int bw    = 4,
  parameter int depth = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  l0_row_feeder_if.slave        bus
);

  // Skew registers: stage i holds the request/instruction launched i cycles ago.
  logic [row-1:1] rd_sk;
  inst_t          inst_sk [1:row-1];

  // Per-row request/instruction as seen by each lane this cycle.
  logic [row-1:0] rd_q;
  inst_t          inst_q [row];

  logic [row-1:0] row_full;
  logic [row-1:0] row_empty;
  logic           any_full;
  logic           push_all;
  logic [2*row-1:0] inst_out_r;

  assign any_full = |row_full;
  // All lanes share one push decision so the rows stay word-aligned even
  // though their occupancies drift apart during a skewed drain.
  assign push_all = bus.wr && !any_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_sk <= '0;
      for (int i = 1; i < row; i++) begin
        inst_sk[i] <= INST_IDLE;
      end
    end else begin
      rd_sk[1]   <= bus.rd;
      inst_sk[1] <= bus.inst_in;
      for (int i = 2; i < row; i++) begin
        rd_sk[i]   <= rd_sk[i-1];
        inst_sk[i] <= inst_sk[i-1];
      end
    end
  end

  always_comb begin
    rd_q      = '0;
    rd_q[0]   = bus.rd;
    inst_q[0] = bus.inst_in;
    for (int i = 1; i < row; i++) begin
      rd_q[i]   = rd_sk[i];
      inst_q[i] = inst_sk[i];
    end
  end

  // Row lanes
  for (genvar g = 0; g < row; g++) begin : g_row
    l0_row_fifo #(
      .bw    (bw),
      .depth (depth)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (push_all),
      .rd    (rd_q[g]),
      .din   (bus.in[g*bw +: bw]),
      .dout  (bus.out[g*bw +: bw]),
      .full  (row_full[g]),
      .empty (row_empty[g]),
      .valid (bus.o_valid[g])
    );
  end

  // Instruction output stage: a request on an empty row must not let the
  // tile load or execute, so the instruction is forced idle unless a pop
  // actually happens.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_out_r <= '0;
    end else begin
      for (int i = 0; i < row; i++) begin
        inst_out_r[2*i +: 2] <= (rd_q[i] && !row_empty[i]) ? inst_q[i] : INST_IDLE;
      end
    end
  end

  assign bus.inst_out = inst_out_r;
  assign bus.o_full   = any_full;
  assign bus.o_empty  = &row_empty;

endmodule

// File: tb/tb_l0_row_feeder.sv
module tb_l0_row_feeder;

  localparam int ROW   = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 64;
  localparam int HIST  = 8192;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  l0_row_feeder_if #(.row(ROW), .bw(BW)) bus ();

  l0_row_feeder #(.row(ROW), .bw(BW), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: one queue per row, plus a history of read launches by
  // cycle. Row i serves the launch made i cycles ago if it came after the
  // last reset.
  logic [BW-1:0]    mq [ROW][$];
  bit               hist_rd   [HIST];
  logic [1:0]       hist_inst [HIST];
  int               cyc = 0;
  int               rst_cyc = -1;
  logic [ROW*BW-1:0] exp_out  = '0;
  logic [2*ROW-1:0]  exp_inst = '0;
  logic [ROW-1:0]    exp_valid = '0;
  logic              exp_full = 1'b0;
  logic              exp_empty = 1'b1;

  function automatic logic model_full();
    for (int i = 0; i < ROW; i++) if (mq[i].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic model_empty();
    for (int i = 0; i < ROW; i++) if (mq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Drive one clock cycle of inputs and advance the model; returns #1 after the edge.
  task automatic cycle(input logic w, input logic [ROW*BW-1:0] d, input logic r,
                       input logic [1:0] ins, input logic rst);
    logic full_pre;
    int s;
    @(negedge clk);
    bus.wr = w; bus.in = d; bus.rd = r; bus.inst_in = ins; reset = rst;
    if (cyc >= HIST) begin
      $display("FAIL cycle_budget cycles=%0d limit=%0d", cyc, HIST);
      $fatal(1, "cycle budget exceeded");
    end
    hist_rd[cyc] = r;
    hist_inst[cyc] = ins;
    if (rst) begin
      for (int i = 0; i < ROW; i++) mq[i].delete();
      exp_out = '0; exp_inst = '0; exp_valid = '0;
      rst_cyc = cyc;
    end else begin
      full_pre = model_full();
      for (int i = 0; i < ROW; i++) begin
        s = cyc - i;
        if (s > rst_cyc && hist_rd[s] && mq[i].size() > 0) begin
          exp_out[i*BW +: BW] = mq[i].pop_front();
          exp_valid[i] = 1'b1;
          exp_inst[2*i +: 2] = hist_inst[s];
        end else begin
          exp_valid[i] = 1'b0;
          exp_inst[2*i +: 2] = 2'b00;
        end
      end
      if (w && !full_pre) for (int i = 0; i < ROW; i++) mq[i].push_back(d[i*BW +: BW]);
    end
    exp_full = model_full();
    exp_empty = model_empty();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ROW*BW-1:0] rand_vec();
    logic [ROW*BW-1:0] v;
    for (int i = 0; i < ROW; i++) v[i*BW +: BW] = BW'($urandom);
    return v;
  endfunction

  task automatic test_reset();
    cycle(1'b0, '0, 1'b0, 2'b00, 1'b1);
    cycle(1'b0, '0, 1'b0, 2'b00, 1'b1);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, '0, 1'b0, 2'b00, 1'b0);
      tests++; if (bus.out !== '0) begin fails++; $display("FAIL reset_out got=%h want=0", bus.out); end
      tests++; if (bus.inst_out !== '0) begin fails++; $display("FAIL reset_inst got=%h want=0", bus.inst_out); end
      tests++; if (bus.o_valid !== '0) begin fails++; $display("FAIL reset_valid got=%h want=0", bus.o_valid); end
      tests++; if (bus.o_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b want=1", bus.o_empty); end
      tests++; if (bus.o_full !== 1'b0) begin fails++; $display("FAIL reset_full got=%b want=0", bus.o_full); end
    end
  endtask

  task automatic test_skew();
    logic [ROW*BW-1:0] v;
    logic [ROW-1:0] want_v;
    for (int i = 0; i < ROW; i++) v[i*BW +: BW] = BW'(i + 1);
    cycle(1'b1, v, 1'b0, 2'b00, 1'b0);
    for (int j = 0; j <= ROW; j++) begin
      cycle(1'b0, '0, (j == 0), 2'b01, 1'b0);
      want_v = '0;
      if (j < ROW) want_v[j] = 1'b1;
      tests++; if (bus.o_valid !== want_v) begin fails++; $display("FAIL skew_valid step=%0d got=%b want=%b", j, bus.o_valid, want_v); end
      if (j < ROW) begin
        tests++; if (bus.out[j*BW +: BW] !== BW'(j + 1)) begin fails++; $display("FAIL skew_data row=%0d got=%h want=%h", j, bus.out[j*BW +: BW], j + 1); end
        tests++; if (bus.inst_out[2*j +: 2] !== 2'b01) begin fails++; $display("FAIL skew_inst row=%0d got=%b want=01", j, bus.inst_out[2*j +: 2]); end
      end
      tests++; if (bus.inst_out !== exp_inst) begin fails++; $display("FAIL skew_inst_all got=%h want=%h", bus.inst_out, exp_inst); end
    end
  endtask

  task automatic drain(input int n, input string tag);
    for (int k = 0; k < n + ROW; k++) begin
      cycle(1'b0, '0, (k < n), 2'(k % 3), 1'b0);
      tests++; if (bus.o_valid !== exp_valid) begin fails++; $display("FAIL %s_valid got=%b want=%b", tag, bus.o_valid, exp_valid); end
      tests++; if (bus.out !== exp_out) begin fails++; $display("FAIL %s_data got=%h want=%h", tag, bus.out, exp_out); end
      tests++; if (bus.inst_out !== exp_inst) begin fails++; $display("FAIL %s_inst got=%h want=%h", tag, bus.inst_out, exp_inst); end
    end
  endtask

  task automatic test_full_wrap();
    logic [ROW*BW-1:0] v;
    for (int k = 0; k < DEPTH; k++) begin
      for (int i = 0; i < ROW; i++) v[i*BW +: BW] = BW'(k + i);
      cycle(1'b1, v, 1'b0, 2'b00, 1'b0);
    end
    tests++; if (bus.o_full !== 1'b1) begin fails++; $display("FAIL full_flag got=%b want=1", bus.o_full); end
    cycle(1'b1, {ROW{4'hF}}, 1'b0, 2'b00, 1'b0);
    tests++; if (bus.o_full !== 1'b1) begin fails++; $display("FAIL full_after_extra got=%b want=1", bus.o_full); end
    drain(DEPTH + 1, "full_drain");
    tests++; if (bus.o_empty !== 1'b1) begin fails++; $display("FAIL full_empty_after got=%b want=1", bus.o_empty); end
    for (int k = 0; k < 3; k++) cycle(1'b1, rand_vec(), 1'b0, 2'b00, 1'b0);
    drain(3, "wrap_drain");
    tests++; if (bus.o_empty !== exp_empty) begin fails++; $display("FAIL wrap_empty got=%b want=%b", bus.o_empty, exp_empty); end
  endtask

  task automatic test_underflow();
    int cnt [ROW];
    logic [ROW*BW-1:0] last;
    for (int i = 0; i < ROW; i++) cnt[i] = 0;
    cycle(1'b1, rand_vec(), 1'b0, 2'b00, 1'b0);
    cycle(1'b1, rand_vec(), 1'b0, 2'b00, 1'b0);
    for (int k = 0; k < 4 + ROW; k++) begin
      cycle(1'b0, '0, (k < 4), 2'b10, 1'b0);
      for (int i = 0; i < ROW; i++) cnt[i] += int'(bus.o_valid[i]);
      tests++; if (bus.out !== exp_out) begin fails++; $display("FAIL under_data got=%h want=%h", bus.out, exp_out); end
      tests++; if (bus.inst_out !== exp_inst) begin fails++; $display("FAIL under_inst got=%h want=%h", bus.inst_out, exp_inst); end
    end
    for (int i = 0; i < ROW; i++) begin
      tests++; if (cnt[i] != 2) begin fails++; $display("FAIL under_count row=%0d got=%0d want=2", i, cnt[i]); end
    end
    last = exp_out;
    tests++; if (bus.out !== last || bus.inst_out !== '0) begin fails++; $display("FAIL under_hold out=%h inst=%h want out=%h inst=0", bus.out, bus.inst_out, last); end
    cycle(1'b1, rand_vec(), 1'b0, 2'b00, 1'b0);
    drain(1, "under_after");
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < DEPTH - 1; k++) cycle(1'b1, rand_vec(), 1'b0, 2'b00, 1'b0);
    for (int k = 0; k < 20 + ROW - 1; k++) begin
      cycle((k >= ROW - 1), rand_vec(), 1'b1, 2'b11, 1'b0);
      tests++; if (bus.o_full !== 1'b0) begin fails++; $display("FAIL simul_full step=%0d got=%b want=0", k, bus.o_full); end
      tests++; if (bus.out !== exp_out) begin fails++; $display("FAIL simul_data got=%h want=%h", bus.out, exp_out); end
      tests++; if (bus.o_valid !== exp_valid) begin fails++; $display("FAIL simul_valid got=%b want=%b", bus.o_valid, exp_valid); end
    end
    drain(DEPTH, "simul_drain");
    tests++; if (bus.o_empty !== 1'b1) begin fails++; $display("FAIL simul_empty got=%b want=1", bus.o_empty); end
  endtask

  task automatic test_reset_mid_drain();
    int guard = 0;
    for (int k = 0; k < 5; k++) cycle(1'b1, rand_vec(), 1'b0, 2'b00, 1'b0);
    cycle(1'b0, '0, 1'b1, 2'b01, 1'b0);
    while (bus.o_valid[3] !== 1'b1 && guard < 20) begin
      cycle(1'b0, '0, 1'b1, 2'b01, 1'b0);
      guard++;
    end
    tests++; if (guard >= 20) begin fails++; $display("FAIL rst_mid_wait got=timeout want=row3 valid"); end
    cycle(1'b0, '0, 1'b1, 2'b01, 1'b1);
    tests++; if (bus.out !== '0 || bus.inst_out !== '0 || bus.o_valid !== '0) begin fails++; $display("FAIL rst_mid_outs out=%h inst=%h valid=%b want all 0", bus.out, bus.inst_out, bus.o_valid); end
    tests++; if (bus.o_empty !== 1'b1) begin fails++; $display("FAIL rst_mid_empty got=%b want=1", bus.o_empty); end
    for (int k = 0; k < ROW; k++) begin
      cycle(1'b0, '0, 1'b0, 2'b00, 1'b0);
      tests++; if (bus.o_valid !== '0) begin fails++; $display("FAIL rst_mid_ghost got=%b want=0", bus.o_valid); end
    end
    cycle(1'b1, rand_vec(), 1'b0, 2'b00, 1'b0);
    cycle(1'b1, rand_vec(), 1'b0, 2'b00, 1'b0);
    drain(3, "rst_mid_after");
  endtask

  task automatic test_random();
    logic rst;
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      cycle(logic'($urandom_range(0, 2) != 0), rand_vec(), logic'($urandom_range(0, 1)),
            2'($urandom), rst);
      tests++; if (bus.out !== exp_out) begin fails++; $display("FAIL rand_data got=%h want=%h", bus.out, exp_out); end
      tests++; if (bus.inst_out !== exp_inst) begin fails++; $display("FAIL rand_inst got=%h want=%h", bus.inst_out, exp_inst); end
      tests++; if (bus.o_valid !== exp_valid) begin fails++; $display("FAIL rand_valid got=%b want=%b", bus.o_valid, exp_valid); end
      tests++; if (bus.o_full !== exp_full) begin fails++; $display("FAIL rand_full got=%b want=%b", bus.o_full, exp_full); end
      tests++; if (bus.o_empty !== exp_empty) begin fails++; $display("FAIL rand_empty got=%b want=%b", bus.o_empty, exp_empty); end
    end
  endtask

  initial begin
    bus.wr = 1'b0; bus.in = '0; bus.rd = 1'b0; bus.inst_in = 2'b00;
    test_reset();
    test_skew();
    test_full_wrap();
    test_underflow();
    test_simultaneous();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
